// File: rtl/m_dram_responder.sv
// m_dram_responder: memory-side responder for the MMU DRAM request interface.
// Serves one 32-bit load or store at a time from a byte-enabled on-chip word array.
// Each request takes a fixed LAT busy cycles. A new request may be accepted in the
// first cycle after busy falls.
//
// Parameters
//   DEPTH_LOG2  log2 of the array depth in 32-bit words
//   LAT         busy cycles per request (1..15)
//   BASE_ADDR   byte address that maps to word 0
//
// Ports
//   CLK           clock; all logic is on the rising edge
//   RST           synchronous active-high reset; aborts an in-flight request
//   w_dram_addr   byte address of the request
//   w_dram_wdata  store data, right-aligned
//   w_dram_we_t   store strobe; wins over w_dram_le when both are high
//   w_dram_le     load strobe
//   w_dram_ctrl   size/sign in funct3 encoding (0 B, 1 H, 2 W, 4 BU, 5 HU, others W)
//   w_dram_busy   request in progress
//   w_dram_odata  last load result, extended and right-aligned
//   w_dram_err    one-cycle out-of-range pulse as busy falls
//
// Optional feature macro: DRAM_RESP_BOUNDS_EN
//   When defined, out-of-range requests still take LAT cycles. Stores to those
//   addresses are dropped, loads return 0, and w_dram_err pulses. When undefined,
//   the word index wraps and w_dram_err stays 0.
module m_dram_responder #(
  parameter int unsigned DEPTH_LOG2 = 14,
  parameter int unsigned LAT        = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] w_dram_addr,
  input  logic [31:0] w_dram_wdata,
  input  logic        w_dram_we_t,
  input  logic        w_dram_le,
  input  logic [2:0]  w_dram_ctrl,
  output logic        w_dram_busy,
  output logic [31:0] w_dram_odata,
  output logic        w_dram_err
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  // StWait covers busy cycles 1..LAT-1, and StDone is busy cycle LAT.
  localparam logic [3:0] CntInit = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        store_q, store_d;
  logic [31:0] odata_q, odata_d;
  logic        err_q, err_d;

  logic [31:0] mem [2**DEPTH_LOG2];

  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  logic                  in_range;
  logic [31:0]           rd_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_data;
  logic [3:0]            st_be;
  logic [31:0]           st_data;
  logic                  mem_we;

  // BASE_ADDR is word aligned, so the low offset bits equal the address byte lane.
  assign offset   = addr_q - BASE_ADDR;
  assign word_idx = offset[DEPTH_LOG2+1:2];
  assign lane     = offset[1:0];

`ifdef DRAM_RESP_BOUNDS_EN
  // Use 33 bits so the upper limit cannot overflow for large DEPTH_LOG2.
  assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < (33'd4 << DEPTH_LOG2));
`else
  logic unused_offset;
  assign unused_offset = ^offset[31:DEPTH_LOG2+2];
  assign in_range      = 1'b1;
`endif

  assign rd_word = mem[word_idx];
  assign ld_byte = 8'(rd_word >> {lane, 3'b000});
  assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    case (ctrl_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = rd_word;
    endcase
    if (!in_range) begin
      ld_data = 32'd0;
    end
  end

  // The store data is replicated across lanes, so a byte enable alone selects the target.
  always_comb begin
    st_be   = 4'b1111;
    st_data = wdata_q;
    case (ctrl_q)
      3'd0, 3'd4: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{wdata_q[7:0]}};
      end
      3'd1, 3'd5: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    store_d = store_q;
    odata_d = odata_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (w_dram_we_t || w_dram_le) begin
          addr_d  = w_dram_addr;
          wdata_d = w_dram_wdata;
          ctrl_d  = w_dram_ctrl;
          store_d = w_dram_we_t;
          cnt_d   = CntInit;
          state_d = (LAT <= 1) ? StDone : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = ~in_range;
        if (store_q) begin
          mem_we = in_range;
        end else begin
          odata_d = ld_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ctrl_q  <= 3'd0;
      store_q <= 1'b0;
      odata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      store_q <= store_d;
      odata_q <= odata_d;
      err_q   <= err_d;
    end
  end

  // The array is not reset. A reset in the commit cycle suppresses the write.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) begin
          mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
    end
  end

  assign w_dram_busy  = (state_q != StIdle);
  assign w_dram_odata = odata_q;
  assign w_dram_err   = err_q;

endmodule

// File: tb/tb_m_dram_responder.sv
// Scoreboard testbench for m_dram_responder. Requests are queued as they are issued.
// A monitor retires each one when busy falls, and checks it against a word-array model.
module tb_m_dram_responder;

  localparam int unsigned DL   = 14;
  localparam int unsigned LAT  = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef DRAM_RESP_BOUNDS_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we_t = 1'b0;
  logic        le = 1'b0;
  logic [2:0]  ctrl = '0;
  logic        busy;
  logic [31:0] odata;
  logic        err;

  always #5 CLK = ~CLK;

  m_dram_responder #(
    .DEPTH_LOG2(DL),
    .LAT       (LAT),
    .BASE_ADDR (BASE)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .w_dram_addr (addr),
    .w_dram_wdata(wdata),
    .w_dram_we_t (we_t),
    .w_dram_le   (le),
    .w_dram_ctrl (ctrl),
    .w_dram_busy (busy),
    .w_dram_odata(odata),
    .w_dram_err  (err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    bit          store;
    bit          fixed;
    logic [31:0] fixed_val;
    string       name;
  } req_t;

  req_t        sb_q[$];
  logic [31:0] mem_m[int unsigned];
  logic [31:0] last_load_m = '0;
  bit          last_known = 1'b1;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit oob(input logic [31:0] a);
    return BoundsEn && ((a < BASE) || ((a - BASE) >= (32'd4 << DL)));
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return ((a - BASE) >> 2) & ((32'd1 << DL) - 32'd1);
  endfunction

  function automatic bit is_byte(input logic [2:0] c);
    return (c == 3'd0) || (c == 3'd4);
  endfunction

  function automatic bit is_half(input logic [2:0] c);
    return (c == 3'd1) || (c == 3'd5);
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [31:0] d, input logic [2:0] c);
    logic [31:0] m;
    if (is_byte(c)) begin
      m = 32'hFF << {a[1:0], 3'b000};
      return (w & ~m) | ((d & 32'hFF) << {a[1:0], 3'b000});
    end
    if (is_half(c)) begin
      m = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      return (w & ~m) | ((d & 32'hFFFF) << (a[1] ? 16 : 0));
    end
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] c);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> {a[1:0], 3'b000}) & 32'hFF;
    h = a[1] ? (w >> 16) : (w & 32'hFFFF);
    case (c)
      3'd0:    return (b < 32'd128) ? b : b + 32'hFFFF_FF00;
      3'd4:    return b;
      3'd1:    return (h < 32'd32768) ? h : h + 32'hFFFF_0000;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Retire one request per falling edge of busy.
  initial begin
    bit          prev_busy;
    bit          done;
    bit          exp_err;
    bit          known;
    int          busy_cnt;
    int unsigned idx;
    req_t        r;
    logic [31:0] w;
    prev_busy = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (RST) begin
        prev_busy   = 1'b0;
        busy_cnt    = 0;
        last_load_m = '0;
        last_known  = 1'b1;
      end else begin
        done    = prev_busy && !busy;
        exp_err = 1'b0;
        if (busy) busy_cnt++;
        if (done) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got busy fall expected none");
          end else begin
            r = sb_q.pop_front();
            check({r.name, "_busy_len"}, 32'(busy_cnt), LAT);
            exp_err = oob(r.addr);
            idx     = widx(r.addr);
            known   = mem_m.exists(idx);
            w       = known ? mem_m[idx] : 32'h0;
            if (r.store) begin
              if (!oob(r.addr)) begin
                if (known || !(is_byte(r.ctrl) || is_half(r.ctrl))) begin
                  mem_m[idx] = model_store(w, r.addr, r.wdata, r.ctrl);
                end
              end
            end else if (oob(r.addr)) begin
              last_load_m = 32'h0;
              last_known  = 1'b1;
            end else begin
              last_load_m = model_load(w, r.addr, r.ctrl);
              last_known  = known;
            end
            if (last_known) check({r.name, "_odata"}, odata, last_load_m);
            if (r.fixed) check({r.name, "_fixed"}, odata, r.fixed_val);
          end
          busy_cnt = 0;
        end
        check("err", {31'd0, err}, {31'd0, exp_err});
        prev_busy = busy;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                       input bit st, input bit ld, input bit fx, input logic [31:0] fv,
                       input string name);
    int   n;
    req_t r;
    n = 0;
    @(negedge CLK);
    while (busy === 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: got busy=1 expected busy=0 within 100 cycles", name);
    end
    addr  = a;
    wdata = d;
    ctrl  = c;
    we_t  = st;
    le    = ld;
    r.addr = a; r.wdata = d; r.ctrl = c; r.store = st; r.fixed = fx; r.fixed_val = fv;
    r.name = name;
    sb_q.push_back(r);
    @(negedge CLK);
    we_t = 1'b0;
    le   = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] a;
    logic [2:0]  c;
    bit          st;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_odata", odata, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);

    // Prefill a pool of 16 words so that partial stores and loads hit known data.
    for (int k = 0; k < 16; k++) begin
      issue(BASE + 32'(4 * k), $urandom, 3'd2, 1'b1, 1'b0, 1'b0, '0, "fill");
    end

    issue(32'h8000_0010, 32'hDEAD_BEEF, 3'd2, 1'b1, 1'b0, 1'b0, '0, "sw_beef");
    issue(32'h8000_0010, 32'h0,         3'd2, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, "lw_beef");
    issue(32'h8000_0010, 32'h1122_3344, 3'd2, 1'b1, 1'b0, 1'b0, '0, "sw_base");
    issue(32'h8000_0013, 32'h0000_00A5, 3'd0, 1'b1, 1'b0, 1'b0, '0, "sb");
    issue(32'h8000_0013, 32'h0,         3'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFA5, "lb");
    issue(32'h8000_0013, 32'h0,         3'd4, 1'b0, 1'b1, 1'b1, 32'h0000_00A5, "lbu");
    issue(32'h8000_0010, 32'h0,         3'd2, 1'b0, 1'b1, 1'b1, 32'hA522_3344, "lw_sb");
    issue(32'h8000_0020, 32'h1357_7531, 3'd2, 1'b1, 1'b0, 1'b0, '0, "sw_h");
    issue(32'h8000_0022, 32'h0000_8001, 3'd1, 1'b1, 1'b0, 1'b0, '0, "sh");
    issue(32'h8000_0022, 32'h0,         3'd1, 1'b0, 1'b1, 1'b1, 32'hFFFF_8001, "lh");
    issue(32'h8000_0022, 32'h0,         3'd5, 1'b0, 1'b1, 1'b1, 32'h0000_8001, "lhu");
    issue(32'h8000_0020, 32'h0,         3'd1, 1'b0, 1'b1, 1'b1, 32'h0000_7531, "lh_lo");
    issue(32'h8000_0020, 32'h0,         3'd2, 1'b0, 1'b1, 1'b1, 32'h8001_7531, "lw_sh");

    // Both strobes high means a store. Strobes raised while busy must be ignored.
    issue(32'h8000_0050, 32'h0000_0055, 3'd2, 1'b1, 1'b1, 1'b0, '0, "sw_both");
    addr = 32'h8000_0050;
    ctrl = 3'd2;
    le   = 1'b1;
    we_t = 1'b1;
    wdata = 32'hFFFF_FFFF;
    @(negedge CLK);
    @(negedge CLK);
    le   = 1'b0;
    we_t = 1'b0;
    issue(32'h8000_0050, 32'h0, 3'd2, 1'b0, 1'b1, 1'b1, 32'h0000_0055, "lw_both");

    // A reset during a store aborts it and clears odata.
    issue(32'h8000_0040, 32'h1234_5678, 3'd2, 1'b1, 1'b0, 1'b0, '0, "sw_pre");
    issue(32'h8000_0040, 32'hCAFE_F00D, 3'd2, 1'b1, 1'b0, 1'b0, '0, "sw_abort");
    @(negedge CLK);
    RST = 1'b1;
    void'(sb_q.pop_back());
    @(negedge CLK);
    RST = 1'b0;
    check("rst_abort_busy", {31'd0, busy}, 32'd0);
    check("rst_abort_odata", odata, 32'd0);
    issue(32'h8000_0040, 32'h0, 3'd2, 1'b0, 1'b1, 1'b1, 32'h1234_5678, "lw_after_abort");

`ifdef DRAM_RESP_BOUNDS_EN
    issue(32'h7FFF_FFFC, 32'h0, 3'd2, 1'b0, 1'b1, 1'b1, 32'h0, "lw_oob");
    issue(BASE + (32'd4 << DL), 32'hA1A5_0001, 3'd2, 1'b1, 1'b0, 1'b0, '0, "sw_oob");
    issue(BASE, 32'h0, 3'd2, 1'b0, 1'b1, 1'b0, '0, "lw_w0");
`else
    issue(BASE + (32'd4 << DL), 32'hA1A5_0001, 3'd2, 1'b1, 1'b0, 1'b0, '0, "sw_alias");
    issue(BASE, 32'h0, 3'd2, 1'b0, 1'b1, 1'b1, 32'hA1A5_0001, "lw_alias");
`endif

    for (int i = 0; i < 300; i++) begin
      a  = BASE + 32'(4 * $urandom_range(15)) + 32'($urandom_range(3));
      st = $urandom_range(1) == 1;
      if ($urandom_range(7) == 0) a = a + (32'd4 << DL);
      if (BoundsEn && $urandom_range(9) == 0) a = BASE - 32'd4 - 32'($urandom_range(3));
      c = st ? 3'($urandom_range(2)) : 3'($urandom_range(7));
      issue(a, $urandom, c, st, st ? ($urandom_range(1) == 1) : 1'b1, 1'b0, '0, "rand");
    end

    n = 0;
    while ((sb_q.size() != 0 || busy === 1'b1) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
